hazard_fwd_unit: RTL and testbench

- Parametrised forwarding, stall and flush controller for the in-order RISC-V pipeline, sitting beside the decode stage.
- Keeps a registered scoreboard of in-flight destination registers, one entry per downstream stage up to FWD_DEPTH.
- Per source operand of the decode-stage instruction, selects a forwarding source or requests a load-use stall.
- Generates multi-cycle flush after a taken redirect and keeps a saturating stall-cycle counter.

---
 rtl/hazard_fwd_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_hazard_fwd_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// Forwarding, load-use stall and redirect-flush controller for the in-order
// RISC-V pipeline. Sits beside decode and tracks the destination registers
// of instructions in the downstream stages so that decode can pick
// forwarding sources, or hold when a load result is not yet available.
module hazard_fwd_unit #(
  parameter int FWD_DEPTH    = 2,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int FSEL_W       = $clog2(FWD_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [31:0]       id_inst,
  input  logic              redirect,
  output logic [FSEL_W-1:0] fwd_a_sel,
  output logic [FSEL_W-1:0] fwd_b_sel,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic [31:0]       stall_count
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_CSR   = 7'b1110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // Extra FLUSH-state cycles after the redirect cycle, which flushes on its own.
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  typedef enum logic {RUN, FLUSH} state_t;

  // ---------------------------------------------------------------------
  // Decode of the instruction in ID
  // ---------------------------------------------------------------------
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       csr_imm;
  logic       use_rs1;
  logic       use_rs2;
  logic       writes_rd;
  logic       is_load;
  logic       inst_unused;

  assign opcode      = id_inst[6:0];
  assign rd          = id_inst[11:7];
  assign csr_imm     = id_inst[14];
  assign rs1         = id_inst[19:15];
  assign rs2         = id_inst[24:20];
  assign inst_unused = ^{id_inst[31:25], id_inst[13:12]};

  // Classify operand usage and register writing by opcode.
  always_comb begin
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    case (opcode)
      OP_R: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        writes_rd = 1'b1;
      end
      OP_S, OP_B: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_IMM, OP_JALR: begin
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
      end
      OP_LOAD: begin
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
        is_load   = 1'b1;
      end
      OP_CSR: begin
        use_rs1   = ~csr_imm;
        writes_rd = 1'b1;
      end
      OP_LUI, OP_AUIPC, OP_JAL: begin
        writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Scoreboard of in-flight destinations, entry k = stage k
  // ---------------------------------------------------------------------
  logic [FWD_DEPTH:1] sb_valid;
  logic [FWD_DEPTH:1] sb_load;
  logic [4:0]         sb_rd [1:FWD_DEPTH];
  logic               issue;

  assign issue = id_valid & ~stall & ~flush & writes_rd & (rd != 5'd0);

  // Entry 1 captures the issuing instruction; stalls and flushes insert a hole.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_valid[1] <= 1'b0;
      sb_load[1]  <= 1'b0;
      sb_rd[1]    <= '0;
    end else begin
      sb_valid[1] <= issue;
      sb_load[1]  <= is_load;
      sb_rd[1]    <= rd;
    end
  end

  for (genvar k = 2; k <= FWD_DEPTH; k++) begin : g_shift
    // Older entries advance one stage every clock.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sb_valid[k] <= 1'b0;
        sb_load[k]  <= 1'b0;
        sb_rd[k]    <= '0;
      end else begin
        sb_valid[k] <= sb_valid[k-1];
        sb_load[k]  <= sb_load[k-1];
        sb_rd[k]    <= sb_rd[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Youngest-match search; chains run from the oldest stage towards stage 1
  // so the smallest matching k ends up at the head of each chain.
  // ---------------------------------------------------------------------
  logic [FSEL_W-1:0]    chain_a_sel [1:FWD_DEPTH+1];
  logic [FSEL_W-1:0]    chain_b_sel [1:FWD_DEPTH+1];
  logic [FWD_DEPTH+1:1] chain_a_haz;
  logic [FWD_DEPTH+1:1] chain_b_haz;
  logic [FWD_DEPTH:1]   hit_a;
  logic [FWD_DEPTH:1]   hit_b;

  assign chain_a_sel[FWD_DEPTH+1] = '0;
  assign chain_b_sel[FWD_DEPTH+1] = '0;
  assign chain_a_haz[FWD_DEPTH+1] = 1'b0;
  assign chain_b_haz[FWD_DEPTH+1] = 1'b0;

  for (genvar k = 1; k <= FWD_DEPTH; k++) begin : g_pick
    localparam logic LOAD_EARLY = (k <= LOAD_LAT);
    assign hit_a[k]       = sb_valid[k] && (sb_rd[k] == rs1);
    assign hit_b[k]       = sb_valid[k] && (sb_rd[k] == rs2);
    assign chain_a_sel[k] = hit_a[k] ? FSEL_W'(k) : chain_a_sel[k+1];
    assign chain_b_sel[k] = hit_b[k] ? FSEL_W'(k) : chain_b_sel[k+1];
    assign chain_a_haz[k] = hit_a[k] ? (sb_load[k] & LOAD_EARLY) : chain_a_haz[k+1];
    assign chain_b_haz[k] = hit_b[k] ? (sb_load[k] & LOAD_EARLY) : chain_b_haz[k+1];
  end

  logic a_live;
  logic b_live;
  logic haz_a;
  logic haz_b;

  // Operand qualifiers: only used, non-x0 sources can forward or stall.
  always_comb begin
    a_live = use_rs1 && (rs1 != 5'd0);
    b_live = use_rs2 && (rs2 != 5'd0);
    haz_a  = a_live && chain_a_haz[1];
    haz_b  = b_live && chain_b_haz[1];
  end

  // ---------------------------------------------------------------------
  // Redirect flush FSM
  // ---------------------------------------------------------------------
  state_t     state;
  state_t     state_nxt;
  logic [2:0] flush_cnt;
  logic [2:0] flush_cnt_nxt;

  // State and remaining-flush counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Redirect (re)loads the count; FLUSH counts down and then drops to RUN.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    if (redirect) begin
      flush_cnt_nxt = FLUSH_RELOAD;
      state_nxt     = (FLUSH_RELOAD != 3'd0) ? FLUSH : RUN;
    end else if (state == FLUSH) begin
      flush_cnt_nxt = flush_cnt - 3'd1;
      if (flush_cnt <= 3'd1) begin
        state_nxt = RUN;
      end
    end
  end

  // Flush is live in the redirect cycle and through the FLUSH state.
  always_comb begin
    flush = redirect | (state == FLUSH);
  end

  // Pipeline control: flush outranks stall and zeroes the selects.
  always_comb begin
    stall     = (haz_a | haz_b) & ~flush;
    bubble    = flush | stall;
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    if (!flush) begin
      if (a_live && !haz_a) fwd_a_sel = chain_a_sel[1];
      if (b_live && !haz_b) fwd_b_sel = chain_b_sel[1];
    end
  end

  // Saturating count of cycles spent stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: a vector table on the default
// configuration, plus hand sequences on a deeper, slower-load instance.
module tb_hazard_fwd_unit;

  logic        clk;
  logic        reset_n;
  logic        id_valid;
  logic [31:0] id_inst;
  logic        redirect;

  logic [1:0]  a_fsel_a, a_fsel_b;
  logic        a_stall, a_bubble, a_flush;
  logic [31:0] a_count;
  logic [1:0]  b_fsel_a, b_fsel_b;
  logic        b_stall, b_bubble, b_flush;
  logic [31:0] b_count;

  int n_vec;
  int n_bad;

  hazard_fwd_unit #(.FWD_DEPTH(2), .LOAD_LAT(1), .FLUSH_CYCLES(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_inst(id_inst),
    .redirect(redirect), .fwd_a_sel(a_fsel_a), .fwd_b_sel(a_fsel_b),
    .stall(a_stall), .bubble(a_bubble), .flush(a_flush), .stall_count(a_count)
  );

  hazard_fwd_unit #(.FWD_DEPTH(3), .LOAD_LAT(2), .FLUSH_CYCLES(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_inst(id_inst),
    .redirect(redirect), .fwd_a_sel(b_fsel_a), .fwd_b_sel(b_fsel_b),
    .stall(b_stall), .bubble(b_bubble), .flush(b_flush), .stall_count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] inst;
    logic        redir;
    logic [1:0]  a;
    logic [1:0]  b;
    logic        stall;
    logic        bubble;
    logic        flush;
    logic [31:0] cnt;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [4:0] rd, rs1, rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] add_i(input logic [4:0] rd, rs1, rs2);
    return r_op(7'b0000000, 3'b000, rd, rs1, rs2);
  endfunction
  function automatic logic [31:0] i_op(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] lw_i(input logic [4:0] rd, rs1);
    return i_op(7'b0000011, 3'b010, rd, rs1, 12'd0);
  endfunction
  function automatic logic [31:0] sw_i(input logic [4:0] rs2, rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic vec_t mk(input logic v, input logic [31:0] inst, input logic rr,
                              input logic [1:0] a, b, input logic st, bu, fl,
                              input logic [31:0] cnt);
    vec_t r;
    r.valid = v; r.inst = inst; r.redir = rr; r.a = a; r.b = b;
    r.stall = st; r.bubble = bu; r.flush = fl; r.cnt = cnt;
    return r;
  endfunction

  task automatic check(input string name, input logic [1:0] a, b,
                       input logic st, bu, fl, input logic [31:0] cnt, input vec_t e);
    n_vec++;
    if ({a, b, st, bu, fl, cnt} !== {e.a, e.b, e.stall, e.bubble, e.flush, e.cnt}) begin
      n_bad++;
      $display("FAIL %s: got a=%0d b=%0d stall=%0b bubble=%0b flush=%0b count=%0d, want a=%0d b=%0d stall=%0b bubble=%0b flush=%0b count=%0d",
               name, a, b, st, bu, fl, cnt, e.a, e.b, e.stall, e.bubble, e.flush, e.cnt);
    end
  endtask

  task automatic check_b(input string name, input vec_t e);
    check(name, b_fsel_a, b_fsel_b, b_stall, b_bubble, b_flush, b_count, e);
  endtask

  task automatic step_b(input string name, input logic v, input logic [31:0] inst,
                        input logic rr, input logic [1:0] ea, eb,
                        input logic es, ebu, efl, input logic [31:0] ecnt);
    @(negedge clk);
    id_valid = v; id_inst = inst; redirect = rr;
    #2;
    check_b(name, mk(v, inst, rr, ea, eb, es, ebu, efl, ecnt));
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    // valid, inst, redirect | a, b, stall, bubble, flush, stall_count
    vecs[0]  = mk(1, add_i(5, 1, 2),        0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, r_op(7'b0100000, 3'b000, 6, 5, 3), 0, 1, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, r_op(7'b0000000, 3'b110, 7, 5, 0), 0, 2, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, lw_i(5, 1),            0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, add_i(6, 5, 5),        0, 0, 0, 1, 1, 0, 0);
    vecs[5]  = mk(1, add_i(6, 5, 5),        0, 2, 2, 0, 0, 0, 1);
    vecs[6]  = mk(1, i_op(7'b0010011, 3'b000, 0, 1, 12'd4), 0, 0, 0, 0, 0, 0, 1);
    vecs[7]  = mk(1, add_i(2, 0, 0),        0, 0, 0, 0, 0, 0, 1);
    vecs[8]  = mk(1, add_i(5, 3, 4),        0, 0, 0, 0, 0, 0, 1);
    vecs[9]  = mk(1, sw_i(5, 2, 12'd0),     0, 2, 1, 0, 0, 0, 1);
    vecs[10] = mk(1, add_i(5, 0, 0),        0, 0, 0, 0, 0, 0, 1);
    vecs[11] = mk(1, add_i(5, 0, 0),        0, 0, 0, 0, 0, 0, 1);
    vecs[12] = mk(1, add_i(8, 5, 5),        0, 1, 1, 0, 0, 0, 1);
    vecs[13] = mk(1, 32'h000404B7,          0, 0, 0, 0, 0, 0, 1);
    vecs[14] = mk(1, i_op(7'b0010011, 3'b000, 10, 9, 12'd8), 0, 1, 0, 0, 0, 0, 1);
    vecs[15] = mk(1, add_i(11, 10, 0),      1, 0, 0, 0, 1, 1, 1);
    vecs[16] = mk(1, add_i(12, 11, 10),     0, 0, 2, 0, 0, 0, 1);
    vecs[17] = mk(0, add_i(13, 0, 0),       0, 0, 0, 0, 0, 0, 1);
    vecs[18] = mk(1, add_i(14, 13, 12),     0, 0, 2, 0, 0, 0, 1);
    vecs[19] = mk(1, i_op(7'b1110011, 3'b101, 15, 14, 12'h300), 0, 0, 0, 0, 0, 0, 1);
    vecs[20] = mk(1, i_op(7'b1110011, 3'b001, 16, 15, 12'h300), 0, 1, 0, 0, 0, 0, 1);

    reset_n = 1'b0; id_valid = 1'b0; id_inst = '0; redirect = 1'b0;
    #12;
    check("reset_a", a_fsel_a, a_fsel_b, a_stall, a_bubble, a_flush, a_count,
          mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    check_b("reset_b", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      id_valid = vecs[i].valid; id_inst = vecs[i].inst; redirect = vecs[i].redir;
      #2;
      check($sformatf("vec%0d", i), a_fsel_a, a_fsel_b, a_stall, a_bubble, a_flush,
            a_count, vecs[i]);
    end

    @(negedge clk);
    reset_n = 1'b0; id_valid = 1'b0; redirect = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Deep instance: writer three slots back forwards from stage 3.
    step_b("d3_w0", 1, add_i(5, 1, 2),  0, 0, 0, 0, 0, 0, 0);
    step_b("d3_w1", 1, add_i(20, 1, 1), 0, 0, 0, 0, 0, 0, 0);
    step_b("d3_w2", 1, add_i(21, 1, 1), 0, 0, 0, 0, 0, 0, 0);
    step_b("d3_use", 1, add_i(22, 5, 0), 0, 3, 0, 0, 0, 0, 0);

    // Two-cycle load-use stall, then forward from stage 3.
    step_b("ll_ld", 1, lw_i(5, 1),       0, 0, 0, 0, 0, 0, 0);
    step_b("ll_s1", 1, add_i(6, 5, 0),   0, 0, 0, 1, 1, 0, 0);
    step_b("ll_s2", 1, add_i(6, 5, 0),   0, 0, 0, 1, 1, 0, 1);
    step_b("ll_go", 1, add_i(6, 5, 0),   0, 3, 0, 0, 0, 0, 2);

    // Redirect on top of a load-use hazard: two flush cycles, no stall.
    step_b("fl_ld", 1, lw_i(5, 1),       0, 0, 0, 0, 0, 0, 2);
    step_b("fl_c1", 1, add_i(6, 5, 0),   1, 0, 0, 0, 1, 1, 2);
    step_b("fl_c2", 1, add_i(7, 5, 6),   0, 0, 0, 0, 1, 1, 2);
    step_b("fl_end", 1, add_i(8, 6, 5),  0, 0, 3, 0, 0, 0, 2);
    step_b("fl_gone", 1, add_i(9, 7, 0), 0, 0, 0, 0, 0, 0, 2);

    // Build stall_count to 5 and reset in the middle of a stall.
    step_b("rs_ld1", 1, lw_i(5, 1),      0, 0, 0, 0, 0, 0, 2);
    step_b("rs_s1", 1, add_i(6, 5, 0),   0, 0, 0, 1, 1, 0, 2);
    step_b("rs_s2", 1, add_i(6, 5, 0),   0, 0, 0, 1, 1, 0, 3);
    step_b("rs_go", 1, add_i(6, 5, 0),   0, 3, 0, 0, 0, 0, 4);
    step_b("rs_ld2", 1, lw_i(5, 1),      0, 0, 0, 0, 0, 0, 4);
    step_b("rs_s3", 1, add_i(6, 5, 0),   0, 0, 0, 1, 1, 0, 4);
    step_b("rs_s4", 1, add_i(6, 5, 0),   0, 0, 0, 1, 1, 0, 5);
    #1;
    reset_n = 1'b0;
    #1;
    check_b("rs_async", mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    id_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step_b("rs_after", 1, add_i(7, 5, 6), 0, 0, 0, 0, 0, 0, 0);
    step_b("rs_after2", 1, add_i(8, 5, 6), 0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
